uart_rx_fifo: RTL
=================

# uart_rx_fifo

Parametrised UART receiver with an integrated receive FIFO. It is the next generation of the fixed 8N1 `rx_uart`. It adds configurable frame format, false-start rejection, majority-vote sampling, parity and framing error detection, and buffering with a valid/pop handshake. It sits between the board `rx` pin and `ctrl_uart`-class consumers, so a slow consumer no longer loses bytes.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD`, 9600: line rate in bit/s.
- `DATA_BITS`, 8: data bits per frame, legal range 5..9, sent LSB first.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 16: number of entries, power of two, minimum 2.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `rx`  in  1  asynchronous serial line, idles high.
- `rx_data`  out  DATA_BITS  head-of-FIFO data (show-ahead).
- `rx_perr`  out  1  parity-error flag stored with the head entry.
- `rx_valid`  out  1  FIFO non-empty.
- `rd_en`  in  1  pop the head entry.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of stored entries.
- `frame_err`  out  1  one-cycle pulse when a frame is dropped for a bad stop bit.
- `overflow`  out  1  one-cycle pulse when a good frame is dropped because the FIFO is full.

## Operation
- **Input sync:** `rx` passes through a 2-flop synchroniser that resets to 1. All logic below uses the synchronised signal `rxs`.
- **Bit period:** `BIT_CNT = (CLK_FREQ + BAUD/2) / BAUD`, which is 5208 at the defaults. `HALF = BIT_CNT/2`.
- **Majority vote:** each bit value is the 2-of-3 majority of `rxs` at bit-counter values HALF-1, HALF and HALF+1.
- **FSM states:** IDLE, START, DATA, PAR, STOP, WAIT_IDLE.
  - IDLE: a falling edge on `rxs` moves to START and clears the bit counter.
  - START: at the centre of the start bit, majority 0 moves to DATA. Majority 1 is a false start and returns to IDLE with nothing recorded.
  - DATA: samples DATA_BITS bits into a shift register, LSB first. Then moves to PAR if `PARITY != 0`, otherwise to STOP.
  - PAR: samples the parity bit. Sets `perr` if the received parity mismatches the data under the selected mode (odd or even).
  - STOP: samples each of the STOP_BITS stop bits at its centre.
    - Any stop bit sampled 0: drop the frame, pulse `frame_err`, go to WAIT_IDLE.
    - All stop bits sampled 1: push `{perr, data}`, go to IDLE immediately, at the stop-bit centre. This allows back-to-back frames.
  - WAIT_IDLE: waits until `rxs` has been 1 for one full BIT_CNT, then goes to IDLE. This swallows break conditions.
- **Parity errors:** frames with a parity error are stored, with `rx_perr` = 1. They are not dropped.
- **FIFO push:** if the FIFO is full and there is no simultaneous pop, the frame is dropped and `overflow` pulses. Push plus pop on a full FIFO is accepted, and the count stays unchanged.
- **FIFO pop:** `rd_en` pops when `rx_valid` = 1. `rd_en` while the FIFO is empty is ignored.
- **Pointers:** read and write pointers wrap modulo FIFO_DEPTH.

## Timing
- **Reset values:**
  - `rx_valid`, `rx_perr`, `frame_err`, `overflow` = 0.
  - `rx_data` = 0.
  - `fifo_count` = 0.
  - FSM in IDLE, sync flops = 1.
- **Sampling latency:**
  - Start is detected 2 cycles after the `rx` falling edge, due to the synchroniser.
  - Bit k (start bit = 0) is decided at `k*BIT_CNT + HALF+1` counts after detection.
- **Push:** the push happens on the cycle after the last stop-bit decision. `rx_valid` and `fifo_count` update on the next edge. `rx_data` is valid in the same cycle that `rx_valid` rises.
- **Pop:** after a pop on edge n, the next entry (or `rx_valid` = 0) is visible after edge n.
- **Pulses:** `frame_err` and `overflow` are registered, exactly one cycle wide, once per offending frame.
- **Reset mid-frame:** discards the partial frame and all FIFO contents. The receiver re-arms only on a new falling edge after reset release.

## Structure
- **Package `uart_pkg`:**
  - parity mode constants PAR_NONE, PAR_ODD, PAR_EVEN;
  - the FSM state encoding;
  - a `bit_cnt(clk_freq, baud)` rounding function, shared with the future `uart_tx_fifo`.
- **Sub-module `sync_fifo`:** parameters WIDTH and DEPTH, show-ahead, with full, empty and count outputs. It is instantiated with WIDTH = DATA_BITS+1.

## Test plan
- **Basic 8N1:** defaults, send 0x73 then 0x03 with one idle bit between them, no reads → `fifo_count` = 2; then pop twice → `rx_data` 0x73 then 0x03, `rx_perr` = 0 for both, `rx_valid` falls after the second pop.
- **Even parity:** `PARITY` = 2, send 0x74 with a correct parity bit (0), then 0x03 with a wrong parity bit (1) → two entries stored, `rx_perr` = 0 then 1.
- **False start and framing error:**
  - Drive `rx` low for 1 µs → no state change, `fifo_count` = 0.
  - Send 0x00 with stop bit = 0, holding the line low for a further 3 bit times → one `frame_err` pulse, nothing stored.
  - Then send 0x55 → received correctly.
- **Overflow:** `FIFO_DEPTH` = 4, send 0x01..0x05 with no reads → one `overflow` pulse on the fifth frame; pops return 0x01..0x04 in order.
- **Simultaneous push and pop:** FIFO full at 4, assert `rd_en` on the push cycle of a fifth frame → no overflow, `fifo_count` stays 4, the oldest entry is removed.
- **Reset mid-frame:** pull `rst` low during the data bits of 0x73, with 2 entries queued → all outputs return to reset values immediately; the next full frame 0xA5 is received as the sole entry.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM encoding and the
// bit-period rounding used by both the receive and transmit blocks.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_START     = 3'd1;
   localparam logic [2:0] ST_DATA      = 3'd2;
   localparam logic [2:0] ST_PAR       = 3'd3;
   localparam logic [2:0] ST_STOP      = 3'd4;
   localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

   // Clock cycles per bit, rounded to nearest.
   function automatic int bit_cnt(input int clk_freq, input int baud);
      return (clk_freq + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is accepted only when
// a pop happens on the same cycle.
module sync_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr, rptr;
   logic             do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_FULL);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   // Head reads as zero when empty so the output is defined out of reset.
   assign rdata   = empty ? '0 : mem[rptr];

   always_ff @(posedge clk)
      if (do_push) mem[wptr] <= wdata;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable frame format, majority-vote sampling,
// parity/framing checks and a show-ahead receive FIFO.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 9600,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rx,
   output logic [DATA_BITS-1:0]          rx_data,
   output logic                          rx_perr,
   output logic                          rx_valid,
   input  logic                          rd_en,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          frame_err,
   output logic                          overflow
);
   localparam int BIT_CNT = bit_cnt(CLK_FREQ, BAUD);
   localparam int HALF    = BIT_CNT / 2;
   localparam int CW      = $clog2(BIT_CNT + 1);
   localparam logic [CW-1:0] C_LAST = CW'(BIT_CNT - 1);
   localparam logic [CW-1:0] C_V0   = CW'(HALF - 1);
   localparam logic [CW-1:0] C_V1   = CW'(HALF);
   localparam logic [CW-1:0] C_DEC  = CW'(HALF + 1);

   logic                 s1, rxs, rxs_q;
   logic [2:0]           arm;
   logic                 fall, dec, bit_v;
   logic                 v0, v1;
   logic [2:0]           state;
   logic [CW-1:0]        cnt;
   logic [3:0]           idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 perr, push, full, empty;
   logic [DATA_BITS:0]   head;

   // arm keeps the reset-to-1 sync flops from faking a falling edge when the
   // line is already low at reset release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1    <= 1'b1;
         rxs   <= 1'b1;
         rxs_q <= 1'b1;
         arm   <= '0;
      end else begin
         s1    <= rx;
         rxs   <= s1;
         rxs_q <= rxs;
         arm   <= {arm[1:0], 1'b1};
      end
   end

   assign fall  = arm[2] & rxs_q & ~rxs;
   assign dec   = (cnt == C_DEC);
   assign bit_v = (v0 & v1) | (v0 & rxs) | (v1 & rxs);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v0 <= 1'b1;
         v1 <= 1'b1;
      end else begin
         if (cnt == C_V0) v0 <= rxs;
         if (cnt == C_V1) v1 <= rxs;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         idx       <= '0;
         shreg     <= '0;
         perr      <= 1'b0;
         push      <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         push      <= 1'b0;
         frame_err <= 1'b0;
         if (state != ST_IDLE && state != ST_WAIT_IDLE)
            cnt <= (cnt == C_LAST) ? '0 : cnt + 1'b1;
         case (state)
            ST_IDLE:
               if (fall) begin
                  state <= ST_START;
                  cnt   <= '0;
               end
            ST_START:
               if (dec) begin
                  idx   <= '0;
                  perr  <= 1'b0;
                  state <= bit_v ? ST_IDLE : ST_DATA;
               end
            ST_DATA:
               if (dec) begin
                  shreg <= {bit_v, shreg[DATA_BITS-1:1]};
                  if (idx == 4'(DATA_BITS - 1)) begin
                     idx   <= '0;
                     state <= (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            ST_PAR:
               if (dec) begin
                  perr  <= (^shreg) ^ bit_v ^ (PARITY == PAR_ODD);
                  state <= ST_STOP;
               end
            ST_STOP:
               if (dec) begin
                  if (!bit_v) begin
                     frame_err <= 1'b1;
                     state     <= ST_WAIT_IDLE;
                     cnt       <= '0;
                  end else if (idx == 4'(STOP_BITS - 1)) begin
                     // Leave at the stop-bit centre so a back-to-back start is caught.
                     push  <= 1'b1;
                     state <= ST_IDLE;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            ST_WAIT_IDLE:
               if (!rxs)                cnt   <= '0;
               else if (cnt == C_LAST)  state <= ST_IDLE;
               else                     cnt   <= cnt + 1'b1;
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) overflow <= 1'b0;
      else      overflow <= push & full & ~rd_en;

   sync_fifo #(
      .WIDTH(DATA_BITS + 1),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (push),
      .wdata({perr, shreg}),
      .pop  (rd_en),
      .rdata(head),
      .full (full),
      .empty(empty),
      .count(fifo_count)
   );

   assign rx_data  = head[DATA_BITS-1:0];
   assign rx_perr  = head[DATA_BITS];
   assign rx_valid = ~empty;

endmodule
